// File: rtl/alu_cmd_seq.sv
// Command sequencer for an external 4-bit ALU: owns a 4-entry register file,
// drives the ALU operands and writes the result back once the ALU has settled.
module alu_cmd_seq #(
  parameter int DRIVE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_rs1,
  input  logic [1:0] cmd_rs2,
  input  logic       cmd_imm_en,
  input  logic [3:0] cmd_imm,
  output logic [2:0] alu_S,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  input  logic [3:0] alu_F,
  input  logic       alu_C,
  input  logic       alu_Z,
  output logic       res_valid,
  output logic [3:0] res_data,
  output logic       res_c,
  output logic       res_z,
  output logic       busy
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [3:0] DRIVE_LOAD = 4'(DRIVE_CYCLES);

  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] rd_q, rd_d;
  logic [2:0] alu_s_q, alu_s_d;
  logic [3:0] alu_a_q, alu_a_d;
  logic [3:0] alu_b_q, alu_b_d;
  logic       res_valid_q, res_valid_d;
  logic [3:0] res_data_q, res_data_d;
  logic       res_c_q, res_c_d;
  logic       res_z_q, res_z_d;
  logic [3:0] regs_q [4];
  logic [3:0] regs_d [4];

  logic [3:0] rs1_val;
  logic [3:0] rs2_val;

  // R0 is hardwired to zero on the read side, so its storage never matters.
  always_comb begin
    rs1_val = (cmd_rs1 == 2'd0) ? 4'd0 : regs_q[cmd_rs1];
    rs2_val = (cmd_rs2 == 2'd0) ? 4'd0 : regs_q[cmd_rs2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    alu_s_d     = alu_s_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_c_d     = res_c_q;
    res_z_d     = res_z_q;
    regs_d      = regs_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          alu_s_d = cmd_op;
          alu_a_d = rs1_val;
          alu_b_d = cmd_imm_en ? cmd_imm : rs2_val;
          rd_d    = cmd_rd;
          cnt_d   = DRIVE_LOAD;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // The ALU inputs have been stable for DRIVE_CYCLES edges once the
        // counter is down to one, so its outputs are safe to sample.
        if (cnt_q <= 4'd1) begin
          res_data_d  = alu_F;
          res_c_d     = alu_C;
          res_z_d     = alu_Z;
          res_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = ST_CAPTURE;
          if (rd_q != 2'd0) begin
            regs_d[rd_q] = alu_F;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      rd_q        <= 2'd0;
      alu_s_q     <= 3'd0;
      alu_a_q     <= 4'd0;
      alu_b_q     <= 4'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= 4'd0;
      res_c_q     <= 1'b0;
      res_z_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= 4'd0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      alu_s_q     <= alu_s_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_c_q     <= res_c_d;
      res_z_q     <= res_z_d;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign alu_S     = alu_s_q;
  assign alu_A     = alu_a_q;
  assign alu_B     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_c     = res_c_q;
  assign res_z     = res_z_q;

endmodule
